// File: rtl/wb_ram_arb2.sv
// Round-robin two-master Wishbone arbiter in front of an 8-bit x 2K RAM slave.
// Optional hung-cycle watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arb2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] m0_addr_i,
    input  logic [7:0]  m0_data_i,
    output logic [7:0]  m0_data_o,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [10:0] m1_addr_i,
    input  logic [7:0]  m1_data_i,
    output logic [7:0]  m1_data_o,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [10:0] s_addr_o,
    output logic [7:0]  s_data_o,
    input  logic [7:0]  s_data_i,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_sel_o,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t state;
    state_t state_next;
    logic   last;
    logic   timeout_hit;

    // Re-arbitration only ever happens from IDLE; a tie goes to whoever was not served last.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            case (state_next)
                GNT0:    last <= 1'b0;
                GNT1:    last <= 1'b1;
                default: last <= last;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] count;
    logic       stalled;

    assign stalled = (((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i)) && !s_ack_i;
    // Firing on count == TIMEOUT-1 makes the error land on the TIMEOUT-th stalled cycle.
    assign timeout_hit = stalled && (count == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= 8'd0;
        end else if (!stalled || timeout_hit) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        s_addr_o  = 11'd0;
        s_data_o  = 8'd0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_sel_o   = 1'b0;
        m0_data_o = 8'd0;
        m1_data_o = 8'd0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        gnt_o     = 2'b00;
        case (state)
            GNT0: begin
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_cyc_o   = m0_cyc_i && !timeout_hit;
                s_stb_o   = m0_stb_i && !timeout_hit;
                m0_data_o = s_data_i;
                m0_ack_o  = m0_stb_i && s_ack_i;
                m0_err_o  = timeout_hit;
                gnt_o     = 2'b01;
            end
            GNT1: begin
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_cyc_o   = m1_cyc_i && !timeout_hit;
                s_stb_o   = m1_stb_i && !timeout_hit;
                m1_data_o = s_data_i;
                m1_ack_o  = m1_stb_i && s_ack_i;
                m1_err_o  = timeout_hit;
                gnt_o     = 2'b10;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

endmodule
